// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the CPU instruction-memory boot path.
//   - XLEN            : CPU word width (bits).
//   - IMEM_DEPTH      : instruction memory depth in words; the instruction
//                       memory and the boot loader both size from this.
//   - IMEM_ADDR_W     : word-address width of the instruction memory.
//   - bl_state_e      : boot loader FSM states (also exported on the debug
//                       state port of imem_boot_loader).
//   - bl_outs_t       : the group of control outputs that are a pure
//                       function of the FSM state.
//   - state_outs()    : maps a state to its control outputs.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN        = 32;
   localparam int IMEM_DEPTH  = 64;
   localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

   // Explicit encodings keep the debug state port stable across edits.
   localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
   localparam logic [2:0] ST_LOAD_ENC  = 3'd1;
   localparam logic [2:0] ST_WRITE_ENC = 3'd2;
   localparam logic [2:0] ST_DONE_ENC  = 3'd3;
   localparam logic [2:0] ST_RUN_ENC   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_LOAD  = ST_LOAD_ENC,
      ST_WRITE = ST_WRITE_ENC,
      ST_DONE  = ST_DONE_ENC,
      ST_RUN   = ST_RUN_ENC
   } bl_state_e;

   typedef struct packed {
      logic byte_ready;
      logic imem_we;
      logic load_done;
      logic pc_reset;
      logic cpu_stall;
   } bl_outs_t;

   // Control outputs seen while the FSM sits in state s. The top registers
   // state_outs(next_state) so every one of these leaves a flop.
   function automatic bl_outs_t state_outs(input bl_state_e s);
      bl_outs_t o;
      o.byte_ready = (s == ST_LOAD);
      o.imem_we    = (s == ST_WRITE);
      o.load_done  = (s == ST_DONE);
      o.pc_reset   = (s == ST_DONE);
      // The core only runs once a load has fully completed.
      o.cpu_stall  = (s != ST_RUN);
      return o;
   endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
//   Collects little-endian bytes into one XLEN-bit word. Byte k of a word
//   (k = 0..3) lands in bits [8k+7:8k]. The byte index wraps to 0 after the
//   fourth byte so the next word starts cleanly without an explicit clear.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   accept_i     in   a byte is consumed this cycle
//   clear_i      in   restart assembly at byte 0 (new load)
//   byte_i       in   byte to place
//   word_full_o  out  this cycle's accepted byte completes the word
//   word_o       out  assembled word (valid once word_full_o has fired)
// -----------------------------------------------------------------------------
module byte_word_assembler
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            accept_i,
   input  logic            clear_i,
   input  logic [7:0]      byte_i,
   output logic            word_full_o,
   output logic [XLEN-1:0] word_o
);

   logic [1:0]      idx_q;
   logic [1:0]      idx_d;
   logic [XLEN-1:0] word_q;
   logic [XLEN-1:0] word_d;

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d  = '0;
         word_d = '0;
      end else if (accept_i) begin
         idx_d                     = idx_q + 2'd1;
         word_d[{idx_q, 3'b000} +: 8] = byte_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   // Combinational so the FSM can leave LOAD on the same edge that
   // captures the last byte.
   assign word_full_o = accept_i && (idx_q == 2'd3);
   assign word_o      = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Loads the CPU instruction memory from a host byte stream, then lets the
//   core run. Bytes are assembled little-endian into 32-bit words and each
//   word is written with a one-cycle write strobe. The CPU is held stalled
//   for the whole load; completion raises load_done and cpu_pc_reset for one
//   cycle, after which cpu_stall drops.
//
//   Byte handshake: a byte transfers on a rising edge where byte_valid and
//   byte_ready are both high. byte_ready depends only on loader state (never
//   on byte_valid); the host may raise or drop byte_valid at any time, and a
//   byte offered while byte_ready is low is simply not consumed.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   load_start    in   one-cycle load request
//   word_count    in   words to load (1..DEPTH), sampled with load_start
//   byte_valid    in   host byte available
//   byte_data     in   host byte
//   byte_ready    out  loader accepts a byte this cycle
//   imem_we       out  instruction memory write strobe
//   imem_waddr    out  instruction memory word address (0 when not writing)
//   imem_wdata    out  instruction memory write data (0 when not writing)
//   cpu_stall     out  freeze CPU PC and register writes
//   cpu_pc_reset  out  one-cycle PC-to-zero pulse at load completion
//   load_done     out  one-cycle pulse at load completion
//   err           out  sticky error (bad count or byte timeout); cleared by
//                      the next accepted load_start
//   dbg_state_o   out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module imem_boot_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH   = IMEM_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              cpu_stall,
   output logic              cpu_pc_reset,
   output logic              load_done,
   output logic              err,
   output bl_state_e         dbg_state_o
);

   localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

   // FSM and datapath registers
   bl_state_e         state_q,  state_d;
   logic [ADDR_W:0]   cnt_q,    cnt_d;     // latched word_count
   logic [ADDR_W-1:0] widx_q,   widx_d;    // word index being assembled
   logic [IDLE_W-1:0] idle_q,   idle_d;    // consecutive byte-less LOAD cycles
   logic              err_q,    err_d;
   bl_outs_t          outs_q;

   // Assembler interface
   logic              accept;
   logic              asm_clear;
   logic              word_full;
   logic [XLEN-1:0]   asm_word;

   logic              count_ok;
   logic [ADDR_W:0]   widx_plus;

   assign accept    = byte_valid && outs_q.byte_ready;
   assign count_ok  = (word_count != '0) && (word_count <= DEPTH_CNT);
   // Widened by one bit so a full-depth load can be recognised as finished
   // without the stored index ever reaching DEPTH.
   assign widx_plus = {1'b0, widx_q} + CNT_ONE;

   byte_word_assembler u_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .accept_i    (accept),
      .clear_i     (asm_clear),
      .byte_i      (byte_data),
      .word_full_o (word_full),
      .word_o      (asm_word)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      widx_d    = widx_q;
      idle_d    = idle_q;
      err_d     = err_q;
      asm_clear = 1'b0;

      case (state_q)
         // IDLE and RUN respond to load_start identically; they differ only
         // in cpu_stall, which comes from state_outs().
         ST_IDLE, ST_RUN: begin
            if (load_start) begin
               if (count_ok) begin
                  state_d   = ST_LOAD;
                  cnt_d     = word_count;
                  widx_d    = '0;
                  idle_d    = '0;
                  err_d     = 1'b0;
                  asm_clear = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            if (accept) begin
               idle_d = '0;
               if (word_full) begin
                  state_d = ST_WRITE;
               end
            end else if (idle_q == IDLE_LAST) begin
               // TIMEOUT consecutive cycles without a byte: abandon the load.
               idle_d  = '0;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end

         ST_WRITE: begin
            if (widx_plus == cnt_q) begin
               widx_d  = '0;
               state_d = ST_DONE;
            end else begin
               widx_d  = widx_plus[ADDR_W-1:0];
               state_d = ST_LOAD;
            end
         end

         ST_DONE: begin
            state_d = ST_RUN;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         idle_q  <= '0;
         err_q   <= 1'b0;
         outs_q  <= state_outs(ST_IDLE);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         idle_q  <= idle_d;
         err_q   <= err_d;
         outs_q  <= state_outs(state_d);
      end
   end

   assign byte_ready   = outs_q.byte_ready;
   assign imem_we      = outs_q.imem_we;
   assign load_done    = outs_q.load_done;
   assign cpu_pc_reset = outs_q.pc_reset;
   assign cpu_stall    = outs_q.cpu_stall;
   assign err          = err_q;
   assign dbg_state_o  = state_q;

   // Address and data are forced to zero outside the write strobe so the
   // memory port never shows partially assembled words.
   assign imem_waddr = outs_q.imem_we ? widx_q   : '0;
   assign imem_wdata = outs_q.imem_we ? asm_word : '0;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//   Directed bench for imem_boot_loader. Inputs change and outputs are read on
//   the falling edge. A byte-level model turns every accepted host byte into an
//   expected (address, word) write in exp_q and tracks the load_done pulses
//   owed; one compare process checks writes, pulses and output exclusivity on
//   every cycle. Literal checks pin latency, reset and error behaviour.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;
   import cpu_pkg::*;

   localparam int DEPTH   = 64;
   localparam int ADDR_W  = 6;
   localparam int TIMEOUT = 1024;

   // ---------------------------------------------------------------- clock/reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              load_start = 1'b0;
   logic [ADDR_W:0]   word_count = '0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data  = '0;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [XLEN-1:0]   imem_wdata;
   logic              cpu_stall;
   logic              cpu_pc_reset;
   logic              load_done;
   logic              err;
   bl_state_e         dbg_state;

   imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .word_count   (word_count),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .cpu_stall    (cpu_stall),
      .cpu_pc_reset (cpu_pc_reset),
      .load_done    (load_done),
      .err          (err),
      .dbg_state_o  (dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_err    = 0;

   logic [ADDR_W+XLEN-1:0] exp_q[$];
   logic [7:0]             m_bytes[$];
   int                     m_addr         = 0;
   int                     m_count        = 0;
   int                     m_done_pending = 0;
   int                     n_writes       = 0;
   int                     n_dones        = 0;
   logic [ADDR_W+XLEN-1:0] cmp_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A load with count 1..DEPTH restarts address and byte collection.
   task automatic model_start(input int count);
      m_count = count;
      m_addr  = 0;
      m_bytes.delete();
   endtask

   // Every 4 accepted bytes form one little-endian word at the next address.
   task automatic model_byte(input logic [7:0] b);
      logic [XLEN-1:0] w;
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
         w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
         exp_q.push_back({ADDR_W'(m_addr), w});
         m_bytes.delete();
         m_addr++;
         if (m_addr == m_count) m_done_pending++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("pc_reset_with_done", cpu_pc_reset, load_done);
         if (imem_we || load_done || cpu_pc_reset)
            check("ready_exclusive", byte_ready, 0);
         if (!cpu_stall)
            check("stall_while_loading", {byte_ready, imem_we}, 0);
         if (imem_we) begin
            n_writes++;
            check("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cmp_e = exp_q.pop_front();
               check("write_addr", imem_waddr, cmp_e[ADDR_W+XLEN-1:XLEN]);
               check("write_data", imem_wdata, cmp_e[XLEN-1:0]);
            end
         end
         if (load_done) begin
            n_dones++;
            check("done_expected", m_done_pending > 0, 1);
            if (m_done_pending > 0) m_done_pending--;
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   // All drivers are entered and left on a falling edge.
   task automatic start_load(input int count);
      load_start = 1'b1;
      word_count = (ADDR_W + 1)'(count);
      if (count >= 1 && count <= DEPTH) model_start(count);
      @(negedge clk);
      load_start = 1'b0;
      word_count = '0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited     = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready) begin
         check("byte_accept_wait", byte_ready, 1);
         byte_valid = 1'b0;
         return;
      end
      model_byte(b);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [XLEN-1:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         send_byte(w[8*k +: 8]);
      end
   endtask

   function automatic logic [XLEN-1:0] word_for(input int i);
      return {8'(i * 7 + 1), 8'(i ^ 8'h5a), 8'(255 - i), 8'(i)};
   endfunction

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   int wr0, dn0;

   initial begin
      // Power-on reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("por_state", dbg_state, ST_IDLE);
      check("por_stall", cpu_stall, 1);
      check("por_ready", byte_ready, 0);
      check("por_we", imem_we, 0);
      check("por_err", err, 0);
      check("por_done", load_done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Bytes offered in IDLE are not taken
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (3) @(negedge clk);
      check("idle_ready", byte_ready, 0);
      byte_valid = 1'b0;

      // Invalid counts: 0 and DEPTH+1
      start_load(0);
      check("cnt0_err", err, 1);
      check("cnt0_state", dbg_state, ST_IDLE);
      check("cnt0_ready", byte_ready, 0);
      start_load(65);
      check("cnt65_err", err, 1);
      check("cnt65_state", dbg_state, ST_IDLE);
      check("invalid_no_write", n_writes, 0);

      // Single-word load, consecutive bytes; start is cycle 0
      start_load(1);
      check("c1_err_cleared", err, 0);
      check("c1_ready", byte_ready, 1);
      check("c1_stall", cpu_stall, 1);
      send_byte(8'h13);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'hfe);
      check("c5_we", imem_we, 1);
      check("c5_addr", imem_waddr, 0);
      check("c5_data", imem_wdata, 32'hfe010113);
      check("c5_ready", byte_ready, 0);
      @(negedge clk);
      check("c6_done", load_done, 1);
      check("c6_pc_reset", cpu_pc_reset, 1);
      check("c6_stall", cpu_stall, 1);
      check("c6_we", imem_we, 0);
      @(negedge clk);
      check("c7_stall", cpu_stall, 0);
      check("c7_done", load_done, 0);
      check("c7_state", dbg_state, ST_RUN);

      // RUN: bytes ignored, invalid count flags err but keeps running
      byte_valid = 1'b1;
      byte_data  = 8'haa;
      repeat (4) @(negedge clk);
      byte_valid = 1'b0;
      check("run_ready", byte_ready, 0);
      check("run_no_write", n_writes, 1);
      start_load(0);
      check("run_bad_err", err, 1);
      check("run_bad_state", dbg_state, ST_RUN);
      check("run_bad_stall", cpu_stall, 0);

      // Reload from RUN
      start_load(1);
      check("reload_stall", cpu_stall, 1);
      check("reload_err", err, 0);
      check("reload_state", dbg_state, ST_LOAD);
      send_word(32'h00100093, 1'b0);
      check("reload_we", imem_we, 1);
      check("reload_addr", imem_waddr, 0);
      check("reload_data", imem_wdata, 32'h00100093);
      @(negedge clk);
      check("reload_done", load_done, 1);
      @(negedge clk);
      check("reload_run", cpu_stall, 0);
      check("reload_writes", n_writes, 2);
      check("reload_dones", n_dones, 2);

      // Full-depth load with random gaps; stray starts during WRITE/LOAD
      wr0 = n_writes;
      dn0 = n_dones;
      start_load(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         send_word(word_for(i), 1'b1);
         if (i == 10 || i == 20) begin
            load_start = 1'b1;
            word_count = 7'd1;
            repeat ((i == 10) ? 1 : 2) @(negedge clk);
            load_start = 1'b0;
            word_count = '0;
         end
      end
      repeat (3) @(negedge clk);
      check("full_writes", n_writes - wr0, DEPTH);
      check("full_dones", n_dones - dn0, 1);
      check("full_exp_empty", exp_q.size(), 0);
      check("full_state", dbg_state, ST_RUN);
      check("full_err", err, 0);

      // Timeout: 2 words requested, only 5 bytes delivered
      wr0 = n_writes;
      dn0 = n_dones;
      start_load(2);
      send_word(32'hdeadbeef, 1'b0);
      send_byte(8'h11);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("to_last_idle_state", dbg_state, ST_LOAD);
      check("to_last_idle_err", err, 0);
      @(negedge clk);
      check("to_err", err, 1);
      check("to_state", dbg_state, ST_IDLE);
      check("to_stall", cpu_stall, 1);
      check("to_ready", byte_ready, 0);
      check("to_writes", n_writes - wr0, 1);
      check("to_dones", n_dones - dn0, 0);
      check("to_exp_empty", exp_q.size(), 0);

      // Reset held 3 cycles in the middle of a load
      start_load(2);
      send_byte(8'h01);
      send_byte(8'h02);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_done_pending = 0;
      @(negedge clk);
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_stall", cpu_stall, 1);
      check("rst_ready", byte_ready, 0);
      check("rst_we", imem_we, 0);
      check("rst_err", err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences loading of the CPU instruction memory from an external byte stream (UART/debug bridge side), then releases the core to run.
- Assembles little-endian bytes into 32-bit words and drives the write port of the instruction memory.
- Holds the CPU stalled during load and pulses a PC-reset on completion.
- Sits between the host byte interface and the instruction memory write port / CPU stall + PC control.

Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words.
- ADDR_W, 6, word-address width, equal to clog2(DEPTH).
- TIMEOUT, 1024, maximum idle cycles between bytes while loading before abort.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a load.
- word_count  in  ADDR_W+1  number of words to load; sampled when load_start is accepted.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  word address to write.
- imem_wdata  out  32  word to write.
- cpu_stall  out  1  freezes the CPU PC and register writes.
- cpu_pc_reset  out  1  one-cycle pulse that forces PC to 0.
- load_done  out  1  one-cycle pulse when a load completes.
- err  out  1  sticky error flag; cleared by the next accepted load_start.

Behaviour:
- States: IDLE, LOAD, WRITE, DONE, RUN.
- Reset (rst_n=0 at an edge), from any state including mid-load:
  - State goes to IDLE; internal counters clear.
  - cpu_stall=1; all other outputs 0.
  - Partial memory contents are left as-is.
- IDLE:
  - cpu_stall=1, byte_ready=0.
  - load_start with word_count in 1..DEPTH: latch the count, clear err, clear word index and byte index, go to LOAD.
  - load_start with word_count=0 or word_count>DEPTH: set err, stay in IDLE.
- LOAD:
  - byte_ready=1 and cpu_stall=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte k (k=0..3) is placed in assembly bits [8k+7:8k].
  - On acceptance of byte 3, go to WRITE next cycle.
  - The idle counter increments on every LOAD cycle with no accepted byte and clears on acceptance.
  - When the idle counter reaches TIMEOUT-1 with no byte that cycle: set err, go to IDLE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_waddr=word index, imem_wdata=assembled word; byte_ready=0.
  - Next cycle the word index increments.
  - If the incremented index equals the latched count, go to DONE; otherwise go to LOAD with byte index 0.
- DONE (one cycle): load_done=1, cpu_pc_reset=1, cpu_stall=1. Then go to RUN.
- RUN:
  - cpu_stall=0.
  - load_start with a valid count: cpu_stall=1 from the next cycle, go to LOAD (reload).
  - load_start with an invalid count: set err, stay in RUN.
- Latency: a 1-word load with bytes on consecutive cycles gives:
  - start accepted at cycle 0;
  - bytes accepted at cycles 1–4;
  - imem_we at cycle 5;
  - load_done at cycle 6;
  - cpu_stall=0 from cycle 7.
- Boundary conditions:
  - byte_valid outside LOAD is ignored; no byte is consumed.
  - load_start during LOAD or WRITE is ignored.
  - The word index never exceeds DEPTH-1; word_count=DEPTH writes addresses 0..DEPTH-1 exactly once.
  - imem_we, cpu_pc_reset and load_done are never high simultaneously with byte_ready.

Decomposition:
- Shared package (cpu_pkg):
  - state enum (IDLE/LOAD/WRITE/DONE/RUN) as localparams;
  - XLEN=32;
  - instruction memory DEPTH constant, shared with the instruction memory.
- One natural sub-module: byte_word_assembler. It holds the byte index and the 32-bit shift/placement register, takes accept and clear inputs, and outputs word_full and the word.
- The FSM, word counter and idle timer stay in the top module.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles mid-LOAD → next cycle state is IDLE, cpu_stall=1, byte_ready=0, imem_we=0, err=0.
- Single-word load: word_count=1, bytes 13,01,01,FE on consecutive cycles → imem_we at cycle 5 with addr 0, data 32'hfe010113; load_done and cpu_pc_reset at cycle 6; cpu_stall=0 at cycle 7.
- Full load with gaps: word_count=64, byte_valid toggled randomly with gaps under TIMEOUT → 64 writes at addresses 0..63, in order, each exactly once; data matches the streamed words; one load_done pulse.
- Invalid count: load_start with word_count=0, then again with 65 → err=1, no write, state stays IDLE; a valid start then clears err.
- Timeout: word_count=2, stop after 5 bytes for TIMEOUT cycles → err=1, state IDLE, exactly 1 write issued (addr 0), cpu_stall stays 1.
- Reload from RUN: after a completed load, load_start with word_count=1 → cpu_stall=1 next cycle, new word written to addr 0, load_done pulses again, then cpu_stall=0.
